// File: rtl/l2_mem_responder_if.sv
// Shared request-type package and the dcache <-> L2 responder handshake interface.
package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_operation_e;
endpackage

interface l2_mem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic                          l2_req_valid;
  xentry_pkg::memory_operation_e l2_req_type;
  logic [XLEN-1:0]               l2_req_address;
  logic [XLEN-1:0]               l2_word_to_store;
  logic [XLEN-1:0]               l2_fetched_word;
  logic                          l2_req_fulfilled;

  modport master (
    output l2_req_valid, l2_req_type, l2_req_address, l2_word_to_store,
    input  l2_fetched_word, l2_req_fulfilled
  );

  modport slave (
    input  l2_req_valid, l2_req_type, l2_req_address, l2_word_to_store,
    output l2_fetched_word, l2_req_fulfilled
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Fixed-latency L2 memory responder: captures one request in IDLE, waits
// LATENCY cycles, then performs the access and pulses fulfilled for one cycle.
module l2_mem_responder
  import xentry_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 2048,
  parameter int unsigned     LATENCY      = 2,
  parameter logic [XLEN-1:0] DEFAULT_WORD = 32'hACAB_0012
) (
  input  logic                clk,
  input  logic                reset_n,
  l2_mem_responder_if.slave   bus,
  output logic                err_sticky,
  output logic [15:0]         load_count,
  output logic [15:0]         store_count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [7:0]  LAT8  = 8'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state, state_next;
  logic [7:0]        cnt, cnt_next;
  logic              enter_done;

  memory_operation_e cap_type;
  logic [XLEN-1:0]   cap_addr, cap_data;

  memory_operation_e acc_type;
  logic [XLEN-1:0]   acc_addr, acc_data;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oor, acc_load, acc_store, do_write;

  logic [XLEN-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic [XLEN-1:0]   fetched;
  logic              fulfilled;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; an abort in BUSY wins over the final countdown step.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.l2_req_valid) begin
          if (LAT8 == 8'd0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = LAT8;
          end
        end
      end
      BUSY: begin
        if (!bus.l2_req_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == 8'd1) begin
          state_next = DONE;
          cnt_next   = '0;
          enter_done = 1'b1;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request while idle; later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_type <= LOAD;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (state == IDLE && bus.l2_req_valid) begin
      cap_type <= bus.l2_req_type;
      cap_addr <= bus.l2_req_address;
      cap_data <= bus.l2_word_to_store;
    end
  end

  // With LATENCY=0 the access happens on the capture edge, so use live inputs in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_type = bus.l2_req_type;
      acc_addr = bus.l2_req_address;
      acc_data = bus.l2_word_to_store;
    end else begin
      acc_type = cap_type;
      acc_addr = cap_addr;
      acc_data = cap_data;
    end
  end

  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_oor   = (acc_addr >> (IDX_W + 2)) != '0;
  assign acc_load  = (acc_type == LOAD);
  assign acc_store = (acc_type == STORE);
  assign do_write  = reset_n && enter_done && acc_store && !acc_oor;

  // Backing storage; validity is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[acc_idx] <= acc_data;
  end

  // Per-word written flags, cleared by reset so every word reads the default.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) written <= '0;
    else if (do_write) written[acc_idx] <= 1'b1;
  end

  // Registered completion outputs, error flag and saturating counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fulfilled   <= 1'b0;
      fetched     <= '0;
      err_sticky  <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      fulfilled <= enter_done;
      if (enter_done) begin
        if (acc_load) begin
          fetched <= (acc_oor || !written[acc_idx]) ? DEFAULT_WORD : mem[acc_idx];
          if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
        end
        if (acc_store && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
        if (acc_oor || !(acc_load || acc_store)) err_sticky <= 1'b1;
      end
    end
  end

  assign bus.l2_req_fulfilled = fulfilled;
  assign bus.l2_fetched_word  = fetched;
endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 Parameter XLEN, default 32, word and address width in bits.
REQ-002 Parameter DEPTH, default 2048, number of backing words (power of two); IDX_W = log2(DEPTH).
REQ-003 Parameter LATENCY, default 2, extra wait cycles per request (0..255).
REQ-004 Parameter DEFAULT_WORD, default 32'hACAB_0012, value returned for never-written or out-of-range words.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 l2_req_valid  input  1  requester (dcache) holds high until fulfilled.
REQ-008 l2_req_type  input  memory_operation_e (xentry_pkg)  LOAD or STORE; other encodings are illegal.
REQ-009 l2_req_address  input  XLEN  byte address of the word; bits [1:0] are ignored.
REQ-010 l2_word_to_store  input  XLEN  store data.
REQ-011 l2_fetched_word  output  XLEN  load data, valid while l2_req_fulfilled=1 and held until the next load completes.
REQ-012 l2_req_fulfilled  output  1  one-cycle completion pulse.
REQ-013 err_sticky  output  1  set on illegal type or out-of-range address; cleared only by reset.
REQ-014 load_count / store_count  output  16 each  saturating counts of completed loads and stores.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; all outputs are registered.
REQ-016 IDLE with l2_req_valid=1 at an edge: capture type, address, and store data; go to DONE if LATENCY=0, else go to BUSY with counter=LATENCY.
REQ-017 BUSY: decrement the counter each edge; on the edge where counter=1, go to DONE.
REQ-018 BUSY with l2_req_valid=0 at an edge: abort, return to IDLE, no memory write, no count change, no fulfilled pulse.
REQ-019 On entering DONE, the responder performs the access.
  - STORE: writes the captured data to index addr[IDX_W+1:2] and marks the entry written.
  - LOAD: loads l2_fetched_word with the stored word, or DEFAULT_WORD if the entry is unwritten.
REQ-020 DONE: l2_req_fulfilled=1 for exactly that cycle; the next edge always goes to IDLE, regardless of l2_req_valid.
REQ-021 Latency: fulfilled is high in cycle LATENCY+1 counted from the first cycle valid is sampled (cycle 0); back-to-back requests complete every LATENCY+2 cycles.
REQ-022 Inputs sampled while in BUSY or DONE are ignored; only the IDLE capture matters.
REQ-023 Out-of-range address (any of bits [XLEN-1:IDX_W+2] nonzero):
  - STORE is dropped; LOAD returns DEFAULT_WORD.
  - Fulfilled is still pulsed and err_sticky is set.
REQ-024 Illegal type: fulfilled is pulsed, no write occurs, l2_fetched_word is unchanged, err_sticky is set, counts are unchanged.
REQ-025 Counts increment on entry to DONE for legal LOAD/STORE, including out-of-range accesses, and saturate at 16'hFFFF.
REQ-026 A STORE followed by a LOAD to the same index returns the stored data with no bypass hazard, since writes commit before the later capture.

Reset
REQ-027 While reset_n=0:
  - FSM=IDLE, counter=0;
  - l2_req_fulfilled=0, l2_fetched_word=0;
  - err_sticky=0, load_count=0, store_count=0;
  - all written flags cleared, so every word reads DEFAULT_WORD.
REQ-028 Reset asserted mid-request (BUSY or DONE) discards the request; no write is committed after reset assertion.
REQ-029 First capture is possible at the first rising edge after reset_n rises.

Verification
REQ-030 LATENCY=2, LOAD 0x0000_0040 unwritten -> fulfilled only in cycle 3, l2_fetched_word=0xACAB_0012, load_count=1.
REQ-031 STORE 0xFEED_BEEF to 0x0000_0100, then LOAD 0x0000_0103 -> 0xFEED_BEEF returned, store_count=1, load_count=1, err_sticky=0.
REQ-032 STORE to 0x0000_0200 with valid dropped in BUSY, then LOAD 0x0000_0200 -> no fulfilled for the store, 0xACAB_0012 returned, store_count=0.
REQ-033 STORE 0x1234_5678 to 0x0000_2000 (out of range), then LOAD 0x0000_0000 -> 0xACAB_0012, err_sticky=1, fulfilled pulsed for both.
REQ-034 valid held high across four LOADs with LATENCY=0 -> fulfilled in cycles 1, 3, 5, 7, each exactly one cycle wide.
REQ-035 reset_n pulsed low during BUSY of a STORE to 0x0000_0010 -> fulfilled stays 0, counts=0, a later LOAD 0x0000_0010 returns 0xACAB_0012.
